// File: rtl/ipc_mailbox_mc.sv
// ipc_mailbox_mc: NUM_CH-channel ARM<->Nios mailbox, one DEPTH-word FIFO per direction per channel.
// Define IPC_MBOX_THRESH_EN to add a per-side inbound-count threshold interrupt (IRQ_PEND bit3).
module ipc_mailbox_mc #(
  parameter int NUM_CH = 4,
  parameter int DEPTH = 8,
  parameter int DATA_W = 32,
  localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
  input  logic            clk_clk,
  input  logic            reset_reset,
  input  logic [CH_W+1:0] arm_address,
  input  logic            arm_read,
  input  logic            arm_write,
  input  logic [31:0]     arm_writedata,
  output logic [31:0]     arm_readdata,
  output logic            arm_irq,
  input  logic [CH_W+1:0] nios_address,
  input  logic            nios_read,
  input  logic            nios_write,
  input  logic [31:0]     nios_writedata,
  output logic [31:0]     nios_readdata,
  output logic            nios_irq
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int NF = 2 * NUM_CH;
  // side 0 is ARM, side 1 is Nios; FIFO index {ch, d} holds words pushed by side d
  logic [1:0] rd, wr, hit, irq;
  logic [CH_W-1:0] ch [2];
  logic [1:0] rg [2];
  logic [31:0] wdata [2], rdv [2], rdata [2];
  logic [CH_W:0] fi [2], fo [2];
  logic [DATA_W-1:0] mem [NF][DEPTH];
  logic [AW-1:0] wp [NF], rp [NF];
  logic [CW-1:0] cnt [NF], cnt_nxt [NF];
  logic [NF-1:0] push, pop, push_ok, pop_ok, act;
  logic [3:0] en [2][NUM_CH], pend [2][NUM_CH];
  logic ovf [2][NUM_CH], udf [2][NUM_CH], thr [2][NUM_CH], wsel [2][NUM_CH];

  assign rd = {nios_read, arm_read};
  assign wr = {nios_write, arm_write};
  assign ch[0] = arm_address[CH_W+1:2];
  assign ch[1] = nios_address[CH_W+1:2];
  assign rg[0] = arm_address[1:0];
  assign rg[1] = nios_address[1:0];
  assign wdata[0] = arm_writedata;
  assign wdata[1] = nios_writedata;
  assign arm_readdata = rdata[0];
  assign nios_readdata = rdata[1];
  assign arm_irq = irq[0];
  assign nios_irq = irq[1];

  always_comb begin
    for (int s = 0; s < 2; s++) begin
      hit[s] = 32'(ch[s]) < NUM_CH;
      fo[s] = {ch[s], 1'(s)};
      fi[s] = {ch[s], 1'(1 - s)};
    end
  end

  // a push into a full FIFO is kept only when the opposite side pops it in the same cycle
  always_comb begin
    for (int f = 0; f < NF; f++) begin
      push[f] = wr[f%2] && hit[f%2] && rg[f%2] == 2'd0 && ch[f%2] == CH_W'(f/2);
      pop[f] = rd[1-f%2] && hit[1-f%2] && rg[1-f%2] == 2'd0 && ch[1-f%2] == CH_W'(f/2);
      pop_ok[f] = pop[f] && cnt[f] != '0;
      push_ok[f] = push[f] && (cnt[f] != CW'(DEPTH) || pop_ok[f]);
      cnt_nxt[f] = cnt[f] + CW'(push_ok[f]) - CW'(pop_ok[f]);
    end
  end

  always_ff @(posedge clk_clk) begin
    for (int f = 0; f < NF; f++) begin
      if (reset_reset) begin
        wp[f] <= '0;
        rp[f] <= '0;
        cnt[f] <= '0;
      end else begin
        if (push_ok[f]) wp[f] <= wp[f] + AW'(1);
        if (pop_ok[f]) rp[f] <= rp[f] + AW'(1);
        cnt[f] <= cnt_nxt[f];
      end
    end
  end

  always_ff @(posedge clk_clk) begin
    for (int f = 0; f < NF; f++)
      if (push_ok[f]) mem[f][wp[f]] <= wdata[f%2][DATA_W-1:0];
  end

  always_comb begin
    act = '0;
    for (int s = 0; s < 2; s++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        wsel[s][c] = wr[s] && hit[s] && ch[s] == CH_W'(c);
        pend[s][c] = {thr[s][c], udf[s][c], ovf[s][c], cnt[2*c+1-s] != '0};
        act[s*NUM_CH+c] = |(pend[s][c] & en[s][c]);
      end
    end
  end

  // sticky flags: a hardware set in the same cycle as a W1C wins
  always_ff @(posedge clk_clk) begin
    for (int s = 0; s < 2; s++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (reset_reset) begin
          en[s][c] <= '0;
          ovf[s][c] <= 1'b0;
          udf[s][c] <= 1'b0;
        end else begin
          if (wsel[s][c] && rg[s] == 2'd2) en[s][c] <= wdata[s][3:0];
          ovf[s][c] <= (push[2*c+s] && !push_ok[2*c+s]) || (ovf[s][c] && !(wsel[s][c] && rg[s] == 2'd3 && wdata[s][1]));
          udf[s][c] <= (pop[2*c+1-s] && !pop_ok[2*c+1-s]) || (udf[s][c] && !(wsel[s][c] && rg[s] == 2'd3 && wdata[s][2]));
        end
      end
    end
  end

`ifdef IPC_MBOX_THRESH_EN
  logic [15:0] tval [2][NUM_CH];
  always_ff @(posedge clk_clk) begin
    for (int s = 0; s < 2; s++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (reset_reset) begin
          tval[s][c] <= '0;
          thr[s][c] <= 1'b0;
        end else begin
          if (wsel[s][c] && rg[s] == 2'd1) tval[s][c] <= wdata[s][15:0];
          thr[s][c] <= (tval[s][c] != '0 && 16'(cnt[2*c+1-s]) < tval[s][c] && 16'(cnt_nxt[2*c+1-s]) >= tval[s][c])
                       || (thr[s][c] && !(wsel[s][c] && rg[s] == 2'd3 && wdata[s][3]));
        end
      end
    end
  end
`else
  always_comb begin
    for (int s = 0; s < 2; s++)
      for (int c = 0; c < NUM_CH; c++)
        thr[s][c] = 1'b0;
  end
`endif

  always_comb begin
    for (int s = 0; s < 2; s++)
      rdv[s] = !hit[s] ? 32'd0 :
               rg[s] == 2'd0 ? (cnt[fi[s]] != '0 ? 32'(mem[fi[s]][rp[fi[s]]]) : 32'd0) :
               rg[s] == 2'd1 ? {16'(DEPTH - 32'(cnt[fo[s]])), 16'(cnt[fi[s]])} :
               rg[s] == 2'd2 ? {28'd0, en[s][ch[s]]} : {28'd0, pend[s][ch[s]]};
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      rdata[0] <= '0;
      rdata[1] <= '0;
      irq <= '0;
    end else begin
      rdata[0] <= rd[0] ? rdv[0] : 32'd0;
      rdata[1] <= rd[1] ? rdv[1] : 32'd0;
      irq[0] <= |act[NUM_CH-1:0];
      irq[1] <= |act[NF-1:NUM_CH];
    end
  end
endmodule

// File: tb/tb_ipc_mailbox_mc.sv
// tb_ipc_mailbox_mc: directed and randomized checks of ipc_mailbox_mc against a queue-based mailbox model.
module tb_ipc_mailbox_mc;
  localparam int NC = 4;
  localparam int D = 8;
  logic clk = 1'b0, rst;
  logic [3:0] a_ad, n_ad;
  logic a_r, a_w, n_r, n_w, a_irq, n_irq;
  logic [31:0] a_wd, n_wd, a_rd, n_rd;
  logic [31:0] q [2*NC][$];
  bit [3:0] m_en [2][NC];
  bit m_ovf [2][NC], m_udf [2][NC], m_thr [2][NC];
  int m_t [2][NC];
  logic [31:0] e_rd [2];
  bit e_irq [2];
  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  ipc_mailbox_mc dut (
    .clk_clk(clk), .reset_reset(rst),
    .arm_address(a_ad), .arm_read(a_r), .arm_write(a_w), .arm_writedata(a_wd), .arm_readdata(a_rd), .arm_irq(a_irq),
    .nios_address(n_ad), .nios_read(n_r), .nios_write(n_w), .nios_writedata(n_wd), .nios_readdata(n_rd), .nios_irq(n_irq)
  );

  function automatic logic [3:0] adr(int c, int r);
    return {2'(c), 2'(r)};
  endfunction

  // FIFO d of channel c carries words written by side d; the other side reads it
  function automatic logic [31:0] mread(int s, logic [3:0] ad);
    int c, fi, fo;
    c = int'(ad[3:2]);
    fi = 2*c + 1 - s;
    fo = 2*c + s;
    case (ad[1:0])
      2'd0: return q[fi].size() > 0 ? q[fi][0] : 32'd0;
      2'd1: return {16'(D - q[fo].size()), 16'(q[fi].size())};
      2'd2: return {28'd0, m_en[s][c]};
      default: return {28'd0, m_thr[s][c], m_udf[s][c], m_ovf[s][c], q[fi].size() > 0};
    endcase
  endfunction

  function automatic bit mirq(int s);
    bit r;
    r = 1'b0;
    for (int c = 0; c < NC; c++)
      r |= |({m_thr[s][c], m_udf[s][c], m_ovf[s][c], q[2*c+1-s].size() > 0} & m_en[s][c]);
    return r;
  endfunction

  function automatic void mreset();
    for (int f = 0; f < 2*NC; f++) q[f].delete();
    for (int s = 0; s < 2; s++)
      for (int c = 0; c < NC; c++) begin
        m_en[s][c] = 0; m_ovf[s][c] = 0; m_udf[s][c] = 0; m_thr[s][c] = 0; m_t[s][c] = 0;
      end
  endfunction

  function automatic void mupd(logic r0, logic w0, logic [3:0] ad0, logic [31:0] wd0,
                               logic r1, logic w1, logic [3:0] ad1, logic [31:0] wd1);
    logic r [2], w [2];
    logic [3:0] ad [2];
    logic [31:0] wd [2];
    int c, d, old;
    bit pu, po, pu_ok, po_ok;
    r[0] = r0; w[0] = w0; ad[0] = ad0; wd[0] = wd0;
    r[1] = r1; w[1] = w1; ad[1] = ad1; wd[1] = wd1;
    for (int s = 0; s < 2; s++)
      if (w[s] && ad[s][1:0] == 2'd3) begin
        c = int'(ad[s][3:2]);
        if (wd[s][1]) m_ovf[s][c] = 0;
        if (wd[s][2]) m_udf[s][c] = 0;
        if (wd[s][3]) m_thr[s][c] = 0;
      end
    for (int f = 0; f < 2*NC; f++) begin
      d = f % 2;
      c = f / 2;
      pu = w[d] && int'(ad[d][3:2]) == c && ad[d][1:0] == 2'd0;
      po = r[1-d] && int'(ad[1-d][3:2]) == c && ad[1-d][1:0] == 2'd0;
      old = q[f].size();
      po_ok = po && old > 0;
      pu_ok = pu && (old < D || po_ok);
      if (po_ok) void'(q[f].pop_front());
      if (pu_ok) q[f].push_back(wd[d]);
      if (pu && !pu_ok) m_ovf[d][c] = 1;
      if (po && !po_ok) m_udf[1-d][c] = 1;
`ifdef IPC_MBOX_THRESH_EN
      if (m_t[1-d][c] != 0 && old < m_t[1-d][c] && q[f].size() >= m_t[1-d][c]) m_thr[1-d][c] = 1;
`endif
    end
    for (int s = 0; s < 2; s++)
      if (w[s]) begin
        c = int'(ad[s][3:2]);
        if (ad[s][1:0] == 2'd2) m_en[s][c] = wd[s][3:0];
`ifdef IPC_MBOX_THRESH_EN
        if (ad[s][1:0] == 2'd1) m_t[s][c] = int'(wd[s][15:0]);
`endif
      end
  endfunction

  task automatic step(input logic ar, input logic aw, input logic [3:0] aad, input logic [31:0] awd,
                      input logic nr, input logic nw, input logic [3:0] nad, input logic [31:0] nwd);
    e_rd[0] = mread(0, aad);
    e_rd[1] = mread(1, nad);
    e_irq[0] = mirq(0);
    e_irq[1] = mirq(1);
    a_r = ar; a_w = aw; a_ad = aad; a_wd = awd;
    n_r = nr; n_w = nw; n_ad = nad; n_wd = nwd;
    @(posedge clk);
    #1;
    mupd(ar, aw, aad, awd, nr, nw, nad, nwd);
    a_r = 0; a_w = 0; n_r = 0; n_w = 0;
  endtask

  task automatic idle();
    step(0, 0, 4'd0, 32'd0, 0, 0, 4'd0, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1;
    a_r = 0; a_w = 0; n_r = 0; n_w = 0; a_ad = 0; n_ad = 0; a_wd = 0; n_wd = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    mreset();
  endtask

  task automatic test_reset();
    do_reset();
    if (a_rd !== 32'd0) begin n_bad++; $display("FAIL reset_arm_rd: got %h want 0", a_rd); end
    n_cmp++;
    if (n_rd !== 32'd0) begin n_bad++; $display("FAIL reset_nios_rd: got %h want 0", n_rd); end
    n_cmp++;
    if (a_irq !== 1'b0 || n_irq !== 1'b0) begin n_bad++; $display("FAIL reset_irq: got %b%b want 00", a_irq, n_irq); end
    n_cmp++;
    step(1, 0, adr(0, 1), 32'd0, 1, 0, adr(0, 1), 32'd0);
    if (a_rd !== 32'h0008_0000) begin n_bad++; $display("FAIL reset_arm_status: got %h want 00080000", a_rd); end
    n_cmp++;
    if (n_rd !== 32'h0008_0000) begin n_bad++; $display("FAIL reset_nios_status: got %h want 00080000", n_rd); end
    n_cmp++;
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 8; i++) step(0, 1, adr(1, 0), 32'hA5A5_0001 + i, 0, 0, 4'd0, 32'd0);
    step(1, 0, adr(1, 1), 32'd0, 1, 0, adr(1, 1), 32'd0);
    if (n_rd !== 32'h0008_0008) begin n_bad++; $display("FAIL fill_nios_status: got %h want 00080008", n_rd); end
    n_cmp++;
    if (a_rd !== 32'h0000_0000) begin n_bad++; $display("FAIL fill_arm_status: got %h want 00000000", a_rd); end
    n_cmp++;
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 4'd0, 32'd0, 1, 0, adr(1, 0), 32'd0);
      if (n_rd !== 32'hA5A5_0001 + i) begin n_bad++; $display("FAIL drain_word%0d: got %h want %h", i, n_rd, 32'hA5A5_0001 + i); end
      n_cmp++;
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 9; i++) step(0, 1, adr(2, 0), 32'h0200_0000 + i, 0, 0, 4'd0, 32'd0);
    step(1, 0, adr(2, 3), 32'd0, 0, 0, 4'd0, 32'd0);
    if (a_rd !== 32'h2) begin n_bad++; $display("FAIL ovf_pend: got %h want 2", a_rd); end
    n_cmp++;
    step(0, 1, adr(2, 3), 32'h2, 0, 0, 4'd0, 32'd0);
    step(1, 0, adr(2, 3), 32'd0, 0, 0, 4'd0, 32'd0);
    if (a_rd !== 32'h0) begin n_bad++; $display("FAIL ovf_w1c: got %h want 0", a_rd); end
    n_cmp++;
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 4'd0, 32'd0, 1, 0, adr(2, 0), 32'd0);
      if (n_rd !== 32'h0200_0000 + i) begin n_bad++; $display("FAIL ovf_drain%0d: got %h want %h", i, n_rd, 32'h0200_0000 + i); end
      n_cmp++;
    end
  endtask

  task automatic test_irq_latency();
    step(0, 0, 4'd0, 32'd0, 0, 1, adr(3, 2), 32'h1);
    step(0, 1, adr(3, 0), 32'h33, 0, 0, 4'd0, 32'd0);
    if (n_irq !== 1'b0) begin n_bad++; $display("FAIL irq_n1: got %b want 0", n_irq); end
    n_cmp++;
    idle();
    if (n_irq !== 1'b1) begin n_bad++; $display("FAIL irq_n2: got %b want 1", n_irq); end
    n_cmp++;
    if (a_irq !== 1'b0) begin n_bad++; $display("FAIL irq_arm_quiet: got %b want 0", a_irq); end
    n_cmp++;
    step(0, 0, 4'd0, 32'd0, 1, 0, adr(3, 0), 32'd0);
    if (n_rd !== 32'h33 || n_irq !== 1'b1) begin n_bad++; $display("FAIL irq_pop: got %h/%b want 00000033/1", n_rd, n_irq); end
    n_cmp++;
    idle();
    if (n_irq !== 1'b0) begin n_bad++; $display("FAIL irq_fall: got %b want 0", n_irq); end
    n_cmp++;
    step(0, 0, 4'd0, 32'd0, 0, 1, adr(3, 2), 32'h0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) step(0, 1, adr(0, 0), 32'h10 + i, 0, 0, 4'd0, 32'd0);
    step(0, 1, adr(0, 0), 32'h99, 1, 0, adr(0, 0), 32'd0);
    if (n_rd !== 32'h10) begin n_bad++; $display("FAIL b2b_pop: got %h want 10", n_rd); end
    n_cmp++;
    step(1, 0, adr(0, 3), 32'd0, 1, 0, adr(0, 1), 32'd0);
    if (a_rd !== 32'h0) begin n_bad++; $display("FAIL b2b_no_ovf: got %h want 0", a_rd); end
    n_cmp++;
    if (n_rd !== 32'h0008_0008) begin n_bad++; $display("FAIL b2b_count: got %h want 00080008", n_rd); end
    n_cmp++;
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 4'd0, 32'd0, 1, 0, adr(0, 0), 32'd0);
      if (n_rd !== (i < 7 ? 32'h11 + i : 32'h99)) begin n_bad++; $display("FAIL b2b_order%0d: got %h want %h", i, n_rd, (i < 7 ? 32'h11 + i : 32'h99)); end
      n_cmp++;
    end
  endtask

  task automatic test_underflow_thresh();
    step(0, 0, 4'd0, 32'd0, 1, 0, adr(0, 0), 32'd0);
    if (n_rd !== 32'h0) begin n_bad++; $display("FAIL udf_data: got %h want 0", n_rd); end
    n_cmp++;
    step(0, 0, 4'd0, 32'd0, 1, 0, adr(0, 3), 32'd0);
    if (n_rd !== 32'h4) begin n_bad++; $display("FAIL udf_pend: got %h want 4", n_rd); end
    n_cmp++;
    step(0, 0, 4'd0, 32'd0, 0, 1, adr(0, 3), 32'h4);
    step(0, 0, 4'd0, 32'd0, 0, 1, adr(0, 1), 32'h3);
    for (int i = 0; i < 3; i++) step(0, 1, adr(0, 0), 32'h70 + i, 0, 0, 4'd0, 32'd0);
    step(0, 0, 4'd0, 32'd0, 1, 0, adr(0, 3), 32'd0);
`ifdef IPC_MBOX_THRESH_EN
    if (n_rd !== 32'h9) begin n_bad++; $display("FAIL thr_pend: got %h want 9", n_rd); end
`else
    if (n_rd !== 32'h1) begin n_bad++; $display("FAIL thr_pend: got %h want 1", n_rd); end
`endif
    n_cmp++;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) step(0, 1, adr(1, 0), 32'hBEEF_0000 + i, 0, 0, 4'd0, 32'd0);
    do_reset();
    step(1, 0, adr(1, 1), 32'd0, 1, 0, adr(1, 1), 32'd0);
    if (a_rd !== 32'h0008_0000 || n_rd !== 32'h0008_0000) begin n_bad++; $display("FAIL rstmid_status: got %h/%h want 00080000", a_rd, n_rd); end
    n_cmp++;
    step(0, 0, 4'd0, 32'd0, 1, 0, adr(1, 0), 32'd0);
    if (n_rd !== 32'h0) begin n_bad++; $display("FAIL rstmid_data: got %h want 0", n_rd); end
    n_cmp++;
  endtask

  task automatic test_random();
    logic r [2], w [2];
    logic [3:0] ad [2];
    logic [31:0] wd [2];
    int k, c, g;
    for (int n = 0; n < 1500; n++) begin
      for (int s = 0; s < 2; s++) begin
        k = int'($urandom_range(0, 9));
        c = ($urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(0, NC - 1));
        g = int'($urandom_range(0, 6));
        g = g > 3 ? 0 : g;
        r[s] = k >= 3 && k <= 6;
        w[s] = k >= 7;
        ad[s] = adr(c, g);
        wd[s] = g == 0 ? $urandom : g == 1 ? $urandom_range(0, 9) : $urandom_range(0, 15);
      end
      step(r[0], w[0], ad[0], wd[0], r[1], w[1], ad[1], wd[1]);
      if (r[0] && a_rd !== e_rd[0]) begin n_bad++; $display("FAIL rnd_arm_rd cyc%0d addr %h: got %h want %h", n, ad[0], a_rd, e_rd[0]); end
      if (r[0]) n_cmp++;
      if (r[1] && n_rd !== e_rd[1]) begin n_bad++; $display("FAIL rnd_nios_rd cyc%0d addr %h: got %h want %h", n, ad[1], n_rd, e_rd[1]); end
      if (r[1]) n_cmp++;
      if (a_irq !== e_irq[0] || n_irq !== e_irq[1]) begin n_bad++; $display("FAIL rnd_irq cyc%0d: got %b%b want %b%b", n, a_irq, n_irq, e_irq[0], e_irq[1]); end
      n_cmp++;
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_overflow();
    test_irq_latency();
    test_back_to_back();
    test_underflow_thresh();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
